// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - single-cycle processor run controller; define PROC_RUN_WATCHDOG_EN to enable the run watchdog
module proc_run_ctrl #(
    parameter logic [63:0] END_PC     = 64'h40,
    parameter logic [63:0] EXPECTED   = 64'hF,
    parameter int unsigned RST_CYCLES = 1,
    parameter logic [15:0] WDOG_MAX   = 16'hFFFF,
    parameter int unsigned NUM_TESTS  = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic [63:0] runStartPC,
    input  logic [63:0] currentPC,
    input  logic [63:0] dMemOut,
    output logic        procReset_L,
    output logic [63:0] startPC,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  passCount,
    output logic [7:0]  runCount,
    output logic [15:0] cycleCount,
    output logic        allPassed
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Last HOLD cycle index; HOLD spans indices 0..RST_CYCLES-1.
    localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);
    localparam logic [7:0] NUM_TESTS_8 = 8'(NUM_TESTS);

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [63:0] start_pc_q, start_pc_d;
    logic [15:0] cyc_q, cyc_d;
    logic        pass_q, pass_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  run_q, run_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic        wdog_hit;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Watchdog fires when the run has consumed its full cycle allowance.
    always_comb begin
`ifdef PROC_RUN_WATCHDOG_EN
        wdog_hit = (cyc_q == WDOG_MAX);
`else
        wdog_hit = 1'b0;
`endif
    end

    // State register and run bookkeeping; Reset abandons any run in progress.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            hold_q     <= 8'd0;
            start_pc_q <= 64'd0;
            cyc_q      <= 16'd0;
            pass_q     <= 1'b0;
            tmo_q      <= 1'b0;
            run_q      <= 8'd0;
            pcnt_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            start_pc_q <= start_pc_d;
            cyc_q      <= cyc_d;
            pass_q     <= pass_d;
            tmo_q      <= tmo_d;
            run_q      <= run_d;
            pcnt_q     <= pcnt_d;
        end
    end

    // Next-state logic: start is only honoured from IDLE or DONE.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        start_pc_d = start_pc_q;
        cyc_d      = cyc_q;
        pass_d     = pass_q;
        tmo_d      = tmo_q;
        run_d      = run_q;
        pcnt_d     = pcnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_pc_d = runStartPC;
                    cyc_d      = 16'd0;
                    pass_d     = 1'b0;
                    tmo_d      = 1'b0;
                    hold_d     = 8'd0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            RUN: begin
                if (wdog_hit) begin
                    tmo_d   = 1'b1;
                    pass_d  = 1'b0;
                    run_d   = sat_inc8(run_q);
                    state_d = DONE;
                end else if (currentPC >= END_PC) begin
                    state_d = SETTLE;
                end else if (cyc_q != 16'hFFFF) begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            SETTLE: begin
                state_d = CHECK;
            end
            CHECK: begin
                pass_d  = (dMemOut == EXPECTED);
                run_d   = sat_inc8(run_q);
                if (dMemOut == EXPECTED) begin
                    pcnt_d = sat_inc8(pcnt_q);
                end
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Processor reset follows the controller reset directly so it is low the moment Reset rises.
    assign procReset_L = ~Reset & (state_q != HOLD);
    assign startPC     = start_pc_q;
    assign busy        = (state_q == HOLD) || (state_q == RUN) ||
                         (state_q == SETTLE) || (state_q == CHECK);
    assign done        = (state_q == DONE);
    assign pass        = pass_q;
    assign timeout     = tmo_q;
    assign passCount   = pcnt_q;
    assign runCount    = run_q;
    assign cycleCount  = cyc_q;
    assign allPassed   = (run_q == NUM_TESTS_8) && (pcnt_q == NUM_TESTS_8);

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb/tb_proc_run_ctrl.sv - self-checking bench for proc_run_ctrl
module tb_proc_run_ctrl;

    localparam logic [63:0] END_PC     = 64'h40;
    localparam logic [63:0] EXPECTED   = 64'hF;
    localparam int          RST_CYCLES = 3;
    localparam logic [15:0] WDOG       = 16'h0020;
    localparam int          NUM_TESTS  = 2;
`ifdef PROC_RUN_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] runStartPC = 64'd0;
    logic [63:0] pc = 64'd0;
    logic [63:0] dmem = 64'hF;
    logic        procReset_L;
    logic [63:0] startPC;
    logic        busy, done, pass, timeout, allPassed;
    logic [7:0]  passCount, runCount;
    logic [15:0] cycleCount;
    logic        pc_stuck = 1'b0;

    int checks = 0;
    int errors = 0;
    int m_runs = 0;
    int m_passes = 0;

    proc_run_ctrl #(
        .END_PC(END_PC), .EXPECTED(EXPECTED), .RST_CYCLES(RST_CYCLES),
        .WDOG_MAX(WDOG), .NUM_TESTS(NUM_TESTS)
    ) dut (
        .CLK(clk), .Reset(rst), .start(start), .runStartPC(runStartPC),
        .currentPC(pc), .dMemOut(dmem), .procReset_L(procReset_L),
        .startPC(startPC), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .passCount(passCount), .runCount(runCount),
        .cycleCount(cycleCount), .allPassed(allPassed)
    );

    always #5 clk = ~clk;

    // Behavioural processor: loads startPC while held in reset, otherwise steps by 4.
    always @(posedge clk) begin
        if (!procReset_L) pc <= startPC;
        else if (!pc_stuck) pc <= pc + 64'd4;
    end

    // Number of RUN cycles that increment cycleCount for a run starting at s.
    function automatic int exp_cycles(input logic [63:0] s);
        if (s >= END_PC) return 0;
        return int'((END_PC - s + 64'd3) / 64'd4);
    endfunction

    function automatic bit exp_all();
        return (m_runs == NUM_TESTS) && (m_passes == NUM_TESTS);
    endfunction

    task automatic do_start(input logic [63:0] s);
        @(negedge clk);
        runStartPC = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles until done, plus how many of them had procReset_L low.
    task automatic run_once(output int k, output int lows);
        k = 0;
        lows = 0;
        do begin
            @(negedge clk);
            k++;
            if (!procReset_L) lows++;
        end while (!done && k < 3000);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL run_done_bound: done=%0b after %0d cycles, required done=1", done, k);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({procReset_L, busy, done, pass, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 00000", {procReset_L, busy, done, pass, timeout});
        end
        checks++;
        if ({startPC, passCount, runCount, cycleCount} !== 96'd0) begin
            errors++;
            $display("FAIL reset_regs: startPC=%h pc=%0d rc=%0d cc=%0d, required all 0", startPC, passCount, runCount, cycleCount);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (procReset_L !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: procReset_L=%b busy=%b, required 1 0", procReset_L, busy);
        end
        m_runs = 0;
        m_passes = 0;
    endtask

    task automatic test_single_run(input string name, input logic [63:0] s, input logic [63:0] dm);
        int k, lows, n;
        bit timed, ep;
        dmem = dm;
        n = exp_cycles(s);
        timed = WDOG_EN && (n >= int'(WDOG));
        ep = !timed && (dm == EXPECTED);
        do_start(s);
        run_once(k, lows);
        if (m_runs < 255) m_runs++;
        if (ep && m_passes < 255) m_passes++;
        checks++;
        if (k !== (timed ? RST_CYCLES + int'(WDOG) + 2 : RST_CYCLES + n + 4)) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, k, timed ? RST_CYCLES + int'(WDOG) + 2 : RST_CYCLES + n + 4);
        end
        checks++;
        if (lows !== RST_CYCLES) begin
            errors++;
            $display("FAIL %s_hold: procReset_L low %0d cycles, required %0d", name, lows, RST_CYCLES);
        end
        checks++;
        if (cycleCount !== (timed ? WDOG : 16'(n))) begin
            errors++;
            $display("FAIL %s_cycles: got %0d, required %0d", name, cycleCount, timed ? WDOG : 16'(n));
        end
        checks++;
        if (pass !== ep || timeout !== timed || startPC !== s) begin
            errors++;
            $display("FAIL %s_result: pass=%b timeout=%b startPC=%h, required %b %b %h", name, pass, timeout, startPC, ep, timed, s);
        end
        checks++;
        if (runCount !== 8'(m_runs) || passCount !== 8'(m_passes) || allPassed !== exp_all()) begin
            errors++;
            $display("FAIL %s_counts: run=%0d pass=%0d all=%b, required %0d %0d %b", name, runCount, passCount, allPassed, m_runs, m_passes, exp_all());
        end
    endtask

    task automatic test_basic();
        test_single_run("basic", 64'd0, 64'hF);
    endtask

    task automatic test_back_to_back();
        test_single_run("b2b", 64'd0, 64'hF);
        checks++;
        if (allPassed !== 1'b1) begin
            errors++;
            $display("FAIL b2b_allpassed: got %b, required 1", allPassed);
        end
    endtask

    task automatic test_fail_code();
        test_single_run("failcode", 64'd0, 64'hE);
    endtask

    task automatic test_start_ignored();
        int k;
        dmem = EXPECTED;
        do_start(64'd0);
        k = 0;
        while (cycleCount != 16'd3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        runStartPC = 64'h20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (startPC !== 64'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start: startPC=%h busy=%b, required 0 1", startPC, busy);
        end
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        m_runs++;
        m_passes++;
        checks++;
        if (cycleCount !== 16'd16 || pass !== 1'b1 || runCount !== 8'(m_runs)) begin
            errors++;
            $display("FAIL ignore_finish: cc=%0d pass=%b rc=%0d, required 16 1 %0d", cycleCount, pass, runCount, m_runs);
        end
    endtask

    task automatic test_random();
        logic [63:0] s, dm;
        for (int i = 0; i < 8; i++) begin
            s = 64'($urandom_range(0, 'h50));
            dm = ($urandom_range(0, 1) == 1) ? EXPECTED : {32'($urandom), 32'($urandom)};
            test_single_run("random", s, dm);
        end
    endtask

    task automatic test_watchdog();
        pc_stuck = 1'b1;
        dmem = EXPECTED;
        if (WDOG_EN) begin
            test_single_run("wdog", 64'h8, EXPECTED);
            pc_stuck = 1'b0;
        end else begin
            do_start(64'h8);
            for (int i = 0; i < 65600; i++) @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0 || cycleCount !== 16'hFFFF) begin
                errors++;
                $display("FAIL nowdog_sat: busy=%b done=%b to=%b cc=%h, required 1 0 0 ffff", busy, done, timeout, cycleCount);
            end
            pc_stuck = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            m_runs = 0;
            m_passes = 0;
        end
    endtask

    task automatic test_mid_reset();
        int k;
        dmem = EXPECTED;
        do_start(64'd0);
        k = 0;
        while (cycleCount != 16'd5 && k < 200) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        #1;
        m_runs = 0;
        m_passes = 0;
        checks++;
        if (busy !== 1'b0 || procReset_L !== 1'b0 || {passCount, runCount, cycleCount} !== 32'd0) begin
            errors++;
            $display("FAIL midreset: busy=%b prl=%b pc=%0d rc=%0d cc=%0d, required 0 0 0 0 0", busy, procReset_L, passCount, runCount, cycleCount);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (procReset_L !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: prl=%b busy=%b done=%b, required 1 0 0", procReset_L, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_fail_code();
        test_start_ignored();
        test_random();
        test_watchdog();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
